// File: rtl/range_scanner_pkg.sv
// range_scanner_pkg
//   Shared types and default constants for the range_scanner slice.
//   - state_e     : sequencer states
//   - *_DEF       : default parameter values for range_scanner
//   - ch_sel_t    : result of a channel search (found flag + index)
//   - find_ch()   : lowest set mask bit at or above a start index
package range_scanner_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_TRIG,
    ST_WAIT_RISE,
    ST_MEASURE,
    ST_GUARD
  } state_e;

  localparam int NCH_DEF          = 4;
  localparam int CNT_W_DEF        = 16;
  localparam int TRIG_CYCLES_DEF  = 10;
  localparam int TIMEOUT_DEF      = 60000;
  localparam int GUARD_CYCLES_DEF = 100;

  // Channel search operates on a mask zero-extended to the largest legal NCH.
  localparam int MAX_CH = 16;

  typedef struct packed {
    logic       found;
    logic [3:0] idx;
  } ch_sel_t;

  // Scan from the top down so the lowest qualifying bit is the one kept.
  function automatic ch_sel_t find_ch(input logic [MAX_CH-1:0] mask,
                                      input logic [4:0]        start);
    ch_sel_t sel;
    sel.found = 1'b0;
    sel.idx   = 4'd0;
    for (int i = MAX_CH - 1; i >= 0; i--) begin
      if (mask[i] && (5'(i) >= start)) begin
        sel.found = 1'b1;
        sel.idx   = 4'(i);
      end
    end
    return sel;
  endfunction

endpackage

// File: rtl/echo_sync.sv
// echo_sync
//   Two-flop synchroniser for a bus of independent asynchronous lines.
//   Ports:
//     clk    in   system clock
//     rst_n  in   asynchronous active-low reset, clears both stages
//     d_i    in   [W]  asynchronous inputs
//     q_o    out  [W]  synchronised outputs (two clk of latency)
module echo_sync #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] meta_q;
  logic [W-1:0] sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/range_scanner.sv
// range_scanner
//   Sequences a set of ultrasonic range sensors: triggers each enabled channel
//   in turn, times the echo pulse and reports one result per channel.
//   Build option: define RANGE_SCANNER_CONT_EN to restart sweeps continuously
//   (ch_mask re-latched at the end of every sweep) instead of one sweep per
//   ask_echo.
//   Ports:
//     clk        in   system clock, rising edge
//     rst_n      in   asynchronous active-low reset
//     ask_echo   in   start a sweep (sampled in IDLE only)
//     ch_mask    in   [NCH]  enabled channels, latched at sweep start
//     echo       in   [NCH]  asynchronous sensor echo lines
//     trig       out  [NCH]  one-hot trigger pulse
//     valid      out  one-cycle result strobe
//     ch_id      out  [CH_W] channel of the held result
//     echo_time  out  [CNT_W] echo high time in clk cycles (all ones on timeout)
//     timeout    out  result is a timeout
//     busy       out  sweep in progress
//
//   state        | meaning
//   -------------+-----------------------------------------------------
//   ST_IDLE      | waiting for ask_echo with a non-zero ch_mask
//   ST_TRIG      | trig[ch] high for TRIG_CYCLES cycles
//   ST_WAIT_RISE | waiting for the echo to rise, bounded by TIMEOUT
//   ST_MEASURE   | counting echo high time, bounded by TIMEOUT
//   ST_GUARD     | dead time after a result, then next channel or IDLE
module range_scanner
  import range_scanner_pkg::*;
#(
  parameter  int NCH          = NCH_DEF,
  parameter  int CNT_W        = CNT_W_DEF,
  parameter  int TRIG_CYCLES  = TRIG_CYCLES_DEF,
  parameter  int TIMEOUT      = TIMEOUT_DEF,
  parameter  int GUARD_CYCLES = GUARD_CYCLES_DEF,
  localparam int CH_W         = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ask_echo,
  input  logic [NCH-1:0]   ch_mask,
  input  logic [NCH-1:0]   echo,
  output logic [NCH-1:0]   trig,
  output logic             valid,
  output logic [CH_W-1:0]  ch_id,
  output logic [CNT_W-1:0] echo_time,
  output logic             timeout,
  output logic             busy
);

  // Phase timer holds load values up to max(TRIG, GUARD) - 1.
  localparam int TMR_MAX = (TRIG_CYCLES > GUARD_CYCLES) ? TRIG_CYCLES : GUARD_CYCLES;
  localparam int TMR_W   = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;

  localparam logic [TMR_W-1:0] TRIG_LOAD  = TMR_W'(TRIG_CYCLES - 1);
  localparam logic [TMR_W-1:0] GUARD_LOAD = TMR_W'(GUARD_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_CNT     = CNT_W'(TIMEOUT);

  state_e           state_q, state_d;
  logic [NCH-1:0]   mask_q, mask_d;
  logic [CH_W-1:0]  ch_q, ch_d;
  logic [TMR_W-1:0] tmr_q, tmr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             valid_q, valid_d;
  logic [CH_W-1:0]  ch_id_q, ch_id_d;
  logic [CNT_W-1:0] echo_time_q, echo_time_d;
  logic             timeout_q, timeout_d;

  logic [NCH-1:0]   echo_s;
  logic             echo_ch;
  logic [CNT_W-1:0] cnt_inc;
  ch_sel_t          first_sel;
  ch_sel_t          next_sel;
  logic             emit;
  logic             emit_to;

  echo_sync #(
    .W (NCH)
  ) u_echo_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (echo),
    .q_o   (echo_s)
  );

  assign echo_ch   = echo_s[ch_q];
  assign cnt_inc   = cnt_q + CNT_W'(1);
  assign first_sel = find_ch(MAX_CH'(ch_mask), 5'd0);
  assign next_sel  = find_ch(MAX_CH'(mask_q), 5'(ch_q) + 5'd1);

  always_comb begin
    state_d     = state_q;
    mask_d      = mask_q;
    ch_d        = ch_q;
    tmr_d       = tmr_q;
    cnt_d       = cnt_q;
    valid_d     = 1'b0;
    ch_id_d     = ch_id_q;
    echo_time_d = echo_time_q;
    timeout_d   = timeout_q;
    emit        = 1'b0;
    emit_to     = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (ask_echo && first_sel.found) begin
          mask_d  = ch_mask;
          ch_d    = CH_W'(first_sel.idx);
          tmr_d   = TRIG_LOAD;
          state_d = ST_TRIG;
        end
      end

      ST_TRIG: begin
        if (tmr_q == '0) begin
          cnt_d   = '0;
          state_d = ST_WAIT_RISE;
        end else begin
          tmr_d = tmr_q - TMR_W'(1);
        end
      end

      ST_WAIT_RISE: begin
        // The rising cycle itself counts as the first high cycle.
        if (echo_ch) begin
          cnt_d   = CNT_W'(1);
          state_d = ST_MEASURE;
        end else if (cnt_inc == TO_CNT) begin
          emit    = 1'b1;
          emit_to = 1'b1;
        end else begin
          cnt_d = cnt_inc;
        end
      end

      ST_MEASURE: begin
        if (echo_ch) begin
          if (cnt_q == TO_CNT) begin
            emit    = 1'b1;
            emit_to = 1'b1;
          end else begin
            cnt_d = cnt_inc;
          end
        end else begin
          emit = 1'b1;
        end
      end

      ST_GUARD: begin
        if (tmr_q == '0) begin
          if (next_sel.found) begin
            ch_d    = CH_W'(next_sel.idx);
            tmr_d   = TRIG_LOAD;
            state_d = ST_TRIG;
          end else begin
`ifdef RANGE_SCANNER_CONT_EN
            if (first_sel.found) begin
              mask_d  = ch_mask;
              ch_d    = CH_W'(first_sel.idx);
              tmr_d   = TRIG_LOAD;
              state_d = ST_TRIG;
            end else begin
              mask_d  = '0;
              state_d = ST_IDLE;
            end
`else
            state_d = ST_IDLE;
`endif
          end
        end else begin
          tmr_d = tmr_q - TMR_W'(1);
        end
      end

      default: state_d = ST_IDLE;
    endcase

    if (emit) begin
      valid_d     = 1'b1;
      ch_id_d     = ch_q;
      timeout_d   = emit_to;
      echo_time_d = emit_to ? '1 : cnt_q;
      tmr_d       = GUARD_LOAD;
      state_d     = ST_GUARD;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      mask_q      <= '0;
      ch_q        <= '0;
      tmr_q       <= '0;
      cnt_q       <= '0;
      valid_q     <= 1'b0;
      ch_id_q     <= '0;
      echo_time_q <= '0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      mask_q      <= mask_d;
      ch_q        <= ch_d;
      tmr_q       <= tmr_d;
      cnt_q       <= cnt_d;
      valid_q     <= valid_d;
      ch_id_q     <= ch_id_d;
      echo_time_q <= echo_time_d;
      timeout_q   <= timeout_d;
    end
  end

  // Decoded from the state register, so reset clears it immediately.
  always_comb begin
    trig = '0;
    if (state_q == ST_TRIG) trig[ch_q] = 1'b1;
  end

  assign valid     = valid_q;
  assign ch_id     = ch_id_q;
  assign echo_time = echo_time_q;
  assign timeout   = timeout_q;
  assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_range_scanner.sv
// tb_range_scanner
//   Directed bench for range_scanner. dut_a uses TIMEOUT=1000 for the normal
//   measurement scenarios, dut_b uses TIMEOUT=200 for the timeout scenarios.
//   Honours RANGE_SCANNER_CONT_EN when selecting the end-of-sweep scenario.
module tb_range_scanner;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        ask_a, ask_b;
  logic [3:0]  mask_a, mask_b, echo_a, echo_b;
  logic [3:0]  trig_a, trig_b;
  logic        valid_a, valid_b, timeout_a, timeout_b, busy_a, busy_b;
  logic [1:0]  ch_id_a, ch_id_b;
  logic [15:0] echo_time_a, echo_time_b;

  range_scanner #(.NCH(4), .CNT_W(16), .TRIG_CYCLES(10), .TIMEOUT(1000), .GUARD_CYCLES(100)) dut_a (
    .clk(clk), .rst_n(rst_n), .ask_echo(ask_a), .ch_mask(mask_a), .echo(echo_a),
    .trig(trig_a), .valid(valid_a), .ch_id(ch_id_a), .echo_time(echo_time_a),
    .timeout(timeout_a), .busy(busy_a));

  range_scanner #(.NCH(4), .CNT_W(16), .TRIG_CYCLES(10), .TIMEOUT(200), .GUARD_CYCLES(100)) dut_b (
    .clk(clk), .rst_n(rst_n), .ask_echo(ask_b), .ch_mask(mask_b), .echo(echo_b),
    .trig(trig_b), .valid(valid_b), .ch_id(ch_id_b), .echo_time(echo_time_b),
    .timeout(timeout_b), .busy(busy_b));

  // Observation mux so one recorder serves both instances.
  logic        sel_b;
  logic [3:0]  trig_x;
  logic        valid_x, timeout_x, busy_x;
  logic [1:0]  ch_id_x;
  logic [15:0] echo_time_x;
  assign trig_x      = sel_b ? trig_b      : trig_a;
  assign valid_x     = sel_b ? valid_b     : valid_a;
  assign timeout_x   = sel_b ? timeout_b   : timeout_a;
  assign busy_x      = sel_b ? busy_b      : busy_a;
  assign ch_id_x     = sel_b ? ch_id_b     : ch_id_a;
  assign echo_time_x = sel_b ? echo_time_b : echo_time_a;

  int n_checks = 0;
  int n_pass   = 0;

  // Recorded sweep observations.
  int         n_res;
  int         r_ch   [16];
  int         r_time [16];
  int         r_to   [16];
  int         r_lat  [16];
  int         r_cyc  [16];
  logic [3:0] trig_seen;
  int         last_trig_len;
  bit         ended;
  int         end_cyc;

  task automatic drive(input bit use_b, input logic ask, input logic [3:0] mask);
    if (use_b) begin ask_b = ask; mask_b = mask; end
    else       begin ask_a = ask; mask_a = mask; end
  endtask

  // Starts a sweep and plays echo pulses: each channel's echo rises right after
  // its trig falls and stays high len cycles (len < 0: never rises).
  task automatic run_sweep(input bit use_b, input logic [3:0] mask,
                           input int l0, input int l1, input int l2, input int l3,
                           input bit noise, input int reask_at, input int clr_at,
                           input int budget);
    int         lens [4];
    int         fall_cyc, echo_rem, echo_ch, tlen;
    logic [3:0] prev_trig, e, cur_mask;
    bit         started;
    lens = '{l0, l1, l2, l3};
    sel_b = use_b;
    n_res = 0; trig_seen = '0; last_trig_len = 0; ended = 0; end_cyc = 0;
    fall_cyc = 0; echo_rem = 0; echo_ch = 0; tlen = 0; prev_trig = '0; started = 0;
    cur_mask = mask;
    @(negedge clk);
    drive(use_b, 1'b1, cur_mask);
    for (int cyc = 0; cyc < budget; cyc++) begin
      @(negedge clk);
      if (cyc == clr_at) cur_mask = '0;
      if (cyc == reask_at)          drive(use_b, 1'b1, 4'b0001);
      else if (cyc == reask_at + 1) begin cur_mask = '0; drive(use_b, 1'b0, cur_mask); end
      else                          drive(use_b, 1'b0, cur_mask);
      if (busy_x) started = 1;
      trig_seen |= trig_x;
      if (trig_x != 4'b0) tlen++;
      if (prev_trig != 4'b0 && trig_x == 4'b0) begin
        last_trig_len = tlen;
        tlen = 0;
        fall_cyc = cyc;
        for (int c = 0; c < 4; c++) if (prev_trig[c]) echo_ch = c;
        echo_rem = lens[echo_ch];
      end
      if (valid_x) begin
        if (n_res < 16) begin
          r_ch[n_res]   = int'(ch_id_x);
          r_time[n_res] = int'(echo_time_x);
          r_to[n_res]   = int'(timeout_x);
          r_lat[n_res]  = cyc - fall_cyc;
          r_cyc[n_res]  = cyc;
        end
        n_res++;
      end
      e = '0;
      if (echo_rem > 0) begin e[echo_ch] = 1'b1; echo_rem--; end
      if (noise) e |= 4'($urandom) & ~mask;
      if (use_b) echo_b = e; else echo_a = e;
      prev_trig = trig_x;
      if (started && !busy_x) begin ended = 1; end_cyc = cyc; break; end
    end
    echo_a = '0; echo_b = '0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; ask_a = 0; ask_b = 0; mask_a = '0; mask_b = '0; echo_a = '0; echo_b = '0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({trig_a, valid_a, timeout_a, busy_a, ch_id_a, echo_time_a} !== 25'd0)
      $display("FAIL reset_a: got %h expected 0", {trig_a, valid_a, timeout_a, busy_a, ch_id_a, echo_time_a});
    else n_pass++;
    n_checks++;
    if ({trig_b, valid_b, timeout_b, busy_b, ch_id_b, echo_time_b} !== 25'd0)
      $display("FAIL reset_b: got %h expected 0", {trig_b, valid_b, timeout_b, busy_b, ch_id_b, echo_time_b});
    else n_pass++;
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_zero_mask();
    ask_a = 1'b1; mask_a = '0;
    repeat (5) @(negedge clk);
    n_checks++;
    if (busy_a !== 1'b0) $display("FAIL zero_mask_busy: got %b expected 0", busy_a);
    else n_pass++;
    ask_a = 1'b0;
  endtask

  task automatic test_single_ch();
    run_sweep(0, 4'b0001, 500, -1, -1, -1, 0, -1, 1, 2000);
    n_checks++;
    if (n_res !== 1) $display("FAIL single_count: got %0d expected 1", n_res); else n_pass++;
    n_checks++;
    if (r_ch[0] !== 0) $display("FAIL single_ch: got %0d expected 0", r_ch[0]); else n_pass++;
    n_checks++;
    if (r_time[0] < 498 || r_time[0] > 502) $display("FAIL single_time: got %0d expected 500+-2", r_time[0]); else n_pass++;
    n_checks++;
    if (r_to[0] !== 0) $display("FAIL single_timeout: got %0d expected 0", r_to[0]); else n_pass++;
    n_checks++;
    if (trig_seen !== 4'b0001) $display("FAIL single_trig_seen: got %b expected 0001", trig_seen); else n_pass++;
    n_checks++;
    if (last_trig_len !== 10) $display("FAIL single_trig_len: got %0d expected 10", last_trig_len); else n_pass++;
    n_checks++;
    if (!ended || (end_cyc - r_cyc[0]) < 99 || (end_cyc - r_cyc[0]) > 101)
      $display("FAIL single_guard: got ended=%0d gap=%0d expected gap 100", ended, end_cyc - r_cyc[0]);
    else n_pass++;
  endtask

  task automatic test_two_ch();
    // A second ask_echo with a different mask arrives mid-sweep and must be ignored.
    run_sweep(0, 4'b1010, -1, 100, -1, 300, 0, 30, -1, 3000);
    n_checks++;
    if (n_res !== 2) $display("FAIL two_count: got %0d expected 2", n_res); else n_pass++;
    n_checks++;
    if (r_ch[0] !== 1 || r_ch[1] !== 3) $display("FAIL two_order: got %0d,%0d expected 1,3", r_ch[0], r_ch[1]); else n_pass++;
    n_checks++;
    if (r_time[0] < 98 || r_time[0] > 102 || r_time[1] < 298 || r_time[1] > 302)
      $display("FAIL two_times: got %0d,%0d expected 100,300", r_time[0], r_time[1]);
    else n_pass++;
    n_checks++;
    if (trig_seen !== 4'b1010) $display("FAIL two_trig_seen: got %b expected 1010", trig_seen); else n_pass++;
    n_checks++;
    if (!ended) $display("FAIL two_end: got busy stuck expected idle"); else n_pass++;
    n_checks++;
    if (ch_id_a !== 2'd3 || echo_time_a < 16'd298 || echo_time_a > 16'd302 || timeout_a !== 1'b0)
      $display("FAIL two_hold: got ch=%0d time=%0d to=%0d expected 3,300,0", ch_id_a, echo_time_a, timeout_a);
    else n_pass++;
  endtask

  task automatic test_no_echo();
    run_sweep(1, 4'b0001, -1, -1, -1, -1, 0, -1, 1, 1000);
    n_checks++;
    if (n_res !== 1 || r_to[0] !== 1 || r_time[0] !== 16'hFFFF || r_ch[0] !== 0)
      $display("FAIL no_echo_result: got n=%0d to=%0d time=%h ch=%0d expected 1,1,ffff,0", n_res, r_to[0], r_time[0], r_ch[0]);
    else n_pass++;
    n_checks++;
    if (r_lat[0] < 199 || r_lat[0] > 201) $display("FAIL no_echo_latency: got %0d expected 200", r_lat[0]); else n_pass++;
  endtask

  task automatic test_long_echo_noise();
    run_sweep(1, 4'b0100, -1, -1, 400, -1, 1, -1, 1, 1500);
    n_checks++;
    if (n_res !== 1 || r_to[0] !== 1 || r_time[0] !== 16'hFFFF || r_ch[0] !== 2)
      $display("FAIL long_echo_result: got n=%0d to=%0d time=%h ch=%0d expected 1,1,ffff,2", n_res, r_to[0], r_time[0], r_ch[0]);
    else n_pass++;
    n_checks++;
    if (trig_seen !== 4'b0100) $display("FAIL long_echo_trig_seen: got %b expected 0100", trig_seen); else n_pass++;
    run_sweep(1, 4'b0001, 80, -1, -1, -1, 1, -1, 1, 1500);
    n_checks++;
    if (n_res !== 1 || r_to[0] !== 0 || r_time[0] < 78 || r_time[0] > 82)
      $display("FAIL noise_result: got n=%0d to=%0d time=%0d expected 1,0,80", n_res, r_to[0], r_time[0]);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    bit seen_hi, fell;
    int n_valid, n_busy;
    sel_b = 0; seen_hi = 0; fell = 0; n_valid = 0; n_busy = 0;
    @(negedge clk); ask_a = 1'b1; mask_a = 4'b0001;
    @(negedge clk); ask_a = 1'b0; mask_a = '0;
    for (int i = 0; i < 100; i++) begin
      if (trig_a[0]) seen_hi = 1;
      if (seen_hi && !trig_a[0]) begin fell = 1; break; end
      @(negedge clk);
    end
    n_checks++;
    if (!fell) $display("FAIL rmid_trig_wait: got no trig pulse expected one"); else n_pass++;
    echo_a = 4'b0001;
    repeat (50) @(negedge clk);
    n_checks++;
    if (busy_a !== 1'b1) $display("FAIL rmid_busy_before: got %b expected 1", busy_a); else n_pass++;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({trig_a, valid_a, timeout_a, busy_a, ch_id_a, echo_time_a} !== 25'd0)
      $display("FAIL rmid_outputs: got %h expected 0", {trig_a, valid_a, timeout_a, busy_a, ch_id_a, echo_time_a});
    else n_pass++;
    @(negedge clk); rst_n = 1'b1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      echo_a = 4'($urandom);
      if (valid_a) n_valid++;
      if (busy_a) n_busy++;
    end
    echo_a = '0;
    n_checks++;
    if (n_valid !== 0 || n_busy !== 0) $display("FAIL rmid_quiet: got valid=%0d busy=%0d expected 0,0", n_valid, n_busy); else n_pass++;
    run_sweep(0, 4'b0001, 60, -1, -1, -1, 0, -1, 1, 1500);
    n_checks++;
    if (n_res !== 1 || r_time[0] < 58 || r_time[0] > 62)
      $display("FAIL rmid_restart: got n=%0d time=%0d expected 1,60", n_res, r_time[0]);
    else n_pass++;
  endtask

  task automatic test_sweep_end();
    int n_busy;
    bit alt_ok;
    n_busy = 0; alt_ok = 1;
`ifdef RANGE_SCANNER_CONT_EN
    run_sweep(0, 4'b0011, 40, 40, -1, -1, 0, -1, 700, 3000);
    n_checks++;
    if (n_res !== 6) $display("FAIL cont_count: got %0d expected 6", n_res); else n_pass++;
    for (int i = 0; i < 6; i++) if (r_ch[i] !== (i % 2)) alt_ok = 0;
    n_checks++;
    if (!alt_ok) $display("FAIL cont_order: got %0d%0d%0d%0d%0d%0d expected 010101", r_ch[0], r_ch[1], r_ch[2], r_ch[3], r_ch[4], r_ch[5]);
    else n_pass++;
    n_checks++;
    if (!ended) $display("FAIL cont_stop: got busy stuck expected idle"); else n_pass++;
`else
    run_sweep(0, 4'b0011, 40, 40, -1, -1, 0, -1, 2000, 3000);
    n_checks++;
    if (n_res !== 2 || !ended) $display("FAIL oneshot_count: got n=%0d ended=%0d expected 2,1", n_res, ended); else n_pass++;
    n_checks++;
    if (r_ch[0] !== 0 || r_ch[1] !== 1) $display("FAIL oneshot_order: got %0d,%0d expected 0,1", r_ch[0], r_ch[1]); else n_pass++;
    mask_a = 4'b0011;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (busy_a) n_busy++;
    end
    mask_a = '0;
    n_checks++;
    if (n_busy !== 0) $display("FAIL oneshot_idle: got busy=%0d cycles expected 0", n_busy); else n_pass++;
`endif
  endtask

  initial begin
    sel_b = 0;
    test_reset();
    test_zero_mask();
    test_single_ch();
    test_two_ch();
    test_no_echo();
    test_long_echo_noise();
    test_reset_mid();
    test_sweep_end();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/range_scanner.md
RANGE_SCANNER -- requirements
Module: range_scanner

Interface
REQ-001 SHALL provide parameter NCH, default 4: number of ultrasonic sensor channels (1..16).
REQ-002 SHALL provide parameter CNT_W, default 16: echo_time counter width.
REQ-003 SHALL provide parameter TRIG_CYCLES, default 10: trigger pulse length in clk cycles.
REQ-004 SHALL provide parameter TIMEOUT, default 60000: cycles allowed for each of the wait-for-rise and measure phases; constraint TIMEOUT <= 2^CNT_W-1.
REQ-005 SHALL provide parameter GUARD_CYCLES, default 100: dead time between channels.
REQ-006 SHALL use one clock; reset is asynchronous and active-low.
REQ-007 clk  input  1  system clock, all logic on rising edge.
REQ-008 rst_n  input  1  asynchronous active-low reset.
REQ-009 ask_echo  input  1  start request; a high level in IDLE starts a sweep.
REQ-010 ch_mask  input  NCH  enabled channels, latched when a sweep starts.
REQ-011 echo  input  NCH  asynchronous sensor echo lines.
REQ-012 trig  output  NCH  one-hot sensor trigger pulses.
REQ-013 valid  output  1  one-cycle result strobe.
REQ-014 ch_id  output  $clog2(NCH) (min 1)  channel of current result.
REQ-015 echo_time  output  CNT_W  measured high time in clk cycles.
REQ-016 timeout  output  1  qualifies valid: no echo, or echo longer than TIMEOUT.
REQ-017 busy  output  1  high in every state except IDLE.

Function
REQ-018 SHALL implement states IDLE, TRIG, WAIT_RISE, MEASURE, GUARD.
REQ-019 IDLE -> TRIG when ask_echo=1 and ch_mask!=0; SHALL latch ch_mask and select the lowest enabled channel; ask_echo=1 with ch_mask=0 SHALL be ignored.
REQ-020 ask_echo SHALL be ignored while busy=1.
REQ-021 TRIG: trig[ch] high for exactly TRIG_CYCLES cycles, all other trig bits low; then WAIT_RISE with counter cleared.
REQ-022 echo SHALL pass through a 2-flop synchroniser; all echo decisions SHALL use the synchronised value only.
REQ-023 WAIT_RISE: on synchronised echo[ch]=1 -> MEASURE with counter=1; else increment; at counter=TIMEOUT SHALL emit a timeout result.
REQ-024 MEASURE: increment per cycle while synchronised echo[ch]=1; on the first cycle it reads 0, SHALL emit valid with echo_time = count and timeout=0.
REQ-025 MEASURE reaching count=TIMEOUT with echo still high SHALL emit a timeout result.
REQ-026 Timeout result: valid=1, timeout=1, echo_time = all ones, ch_id = ch.
REQ-027 valid SHALL be high exactly one cycle per enabled channel per sweep; echo_time, ch_id and timeout SHALL hold until the next valid.
REQ-028 After each result SHALL enter GUARD for GUARD_CYCLES cycles, echo ignored, trig all low.
REQ-029 GUARD end: next higher enabled channel -> TRIG; none left -> IDLE.
REQ-030 Echo activity on non-selected channels SHALL be ignored.

Reset
REQ-031 rst_n low SHALL immediately force state IDLE and trig=0, valid=0, timeout=0, busy=0, echo_time=0, ch_id=0, synchroniser flops=0, latched mask=0, including mid-sweep.
REQ-032 After rst_n deassertion the block SHALL wait in IDLE for a new ask_echo.

Configuration
REQ-033 Macro RANGE_SCANNER_CONT_EN defined: when GUARD ends after the last enabled channel, SHALL re-latch ch_mask and restart at the lowest enabled channel without ask_echo; ch_mask=0 at that point -> IDLE.
REQ-034 Macro not defined: one sweep per ask_echo, return to IDLE as in REQ-029.

Structure
REQ-035 Package range_scanner_pkg SHALL hold the state enum and the default parameter constants.
REQ-036 Sub-module echo_sync (2-flop synchroniser, width parameter) SHALL be instantiated once with width NCH.

Verification
REQ-037 NCH=4, mask=4'b0001, echo[0] high 500 cycles after trig ends -> valid once, ch_id=0, echo_time=500 ±2, timeout=0, busy falls after guard.
REQ-038 mask=4'b1010, distinct echo lengths 100/300 -> results for ch 1 then 3 in order, trig[0] and trig[2] never high.
REQ-039 TIMEOUT=200, echo never rises -> valid with timeout=1, echo_time=16'hFFFF, 200 cycles after the trig pulse ends.
REQ-040 echo held high beyond TIMEOUT=200 -> timeout result; noise on non-selected echo lines -> no effect.
REQ-041 rst_n low during MEASURE -> all outputs 0 at once; no valid after release until a new ask_echo.
REQ-042 RANGE_SCANNER_CONT_EN defined, mask=4'b0011 -> sweeps repeat without ask_echo; mask=0 mid-sweep -> IDLE after the current sweep.
